// File: rtl/approx_seq_pkg.sv
// Shared types and sizing helpers for the slice-sequenced adder.
package approx_seq_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  function automatic int unsigned num_slices(int unsigned width, int unsigned slice);
    return (width + slice - 1) / slice;
  endfunction

  // Index width, never below one bit so a single-slice build still has a legal vector.
  function automatic int unsigned idx_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned IDX_W = idx_width(num_slices(8, 3));

endpackage

// File: rtl/approx_slice_mux.sv
// Picks the current slice of the latched operands and its approx-select bit by index.
module approx_slice_mux
  import approx_seq_pkg::*;
#(
  parameter int unsigned SLICE      = 3,
  parameter int unsigned NUM_SLICES = 3,
  parameter int unsigned IW         = 2
) (
  input  logic [NUM_SLICES*SLICE-1:0] a,
  input  logic [NUM_SLICES*SLICE-1:0] b,
  input  logic [NUM_SLICES-1:0]       mask,
  input  logic [IW-1:0]               idx,
  input  logic                        run,
  output logic [SLICE-1:0]            sl_a,
  output logic [SLICE-1:0]            sl_b,
  output logic                        sl_sel_approx
);

  always_comb begin
    sl_a          = '0;
    sl_b          = '0;
    sl_sel_approx = 1'b0;
    if (run) begin
      for (int i = 0; i < int'(NUM_SLICES); i++) begin
        if (idx == IW'(i)) begin
          sl_a          = a[i*SLICE +: SLICE];
          sl_b          = b[i*SLICE +: SLICE];
          sl_sel_approx = mask[i];
        end
      end
    end
  end

endmodule

// File: rtl/approx_slice_add_seq.sv
// WIDTH-bit adder built by stepping one external SLICE-bit adder unit across the operands,
// LSB slice first, with the inter-slice carry held in a register.
module approx_slice_add_seq
  import approx_seq_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned SLICE = 3,
  parameter int unsigned CNT_W = 16,
  localparam int unsigned NUM_SLICES = num_slices(WIDTH, SLICE)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [WIDTH-1:0]      in_a,
  input  logic [WIDTH-1:0]      in_b,
  input  logic                  in_cin,
  input  logic [NUM_SLICES-1:0] in_approx_mask,
  output logic [SLICE-1:0]      sl_a,
  output logic [SLICE-1:0]      sl_b,
  output logic                  sl_cin,
  output logic                  sl_sel_approx,
  input  logic [SLICE-1:0]      sl_sum,
  input  logic                  sl_cout,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      out_sum,
  output logic                  out_cout,
  output logic                  busy,
  output logic [CNT_W-1:0]      op_count
);

  localparam int unsigned PW = NUM_SLICES * SLICE;
  localparam int unsigned IW = idx_width(NUM_SLICES);
  localparam logic [IW-1:0] LastIdx = IW'(NUM_SLICES - 1);

  state_e                state_q;
  logic [IW-1:0]         idx_q;
  logic                  carry_q;
  logic [PW-1:0]         a_q, b_q, result_q, result_d;
  logic [NUM_SLICES-1:0] mask_q;
  logic                  out_valid_q;
  logic [WIDTH-1:0]      out_sum_q;
  logic                  out_cout_q;
  logic [CNT_W-1:0]      op_count_q;
  logic                  run;
  logic                  final_cout;

  assign run = (state_q == StRun);

  approx_slice_mux #(
    .SLICE      (SLICE),
    .NUM_SLICES (NUM_SLICES),
    .IW         (IW)
  ) u_mux (
    .a             (a_q),
    .b             (b_q),
    .mask          (mask_q),
    .idx           (idx_q),
    .run           (run),
    .sl_a          (sl_a),
    .sl_b          (sl_b),
    .sl_sel_approx (sl_sel_approx)
  );

  always_comb begin
    result_d = result_q;
    for (int i = 0; i < int'(NUM_SLICES); i++) begin
      if (idx_q == IW'(i)) result_d[i*SLICE +: SLICE] = sl_sum;
    end
  end

  // With padding the top sum bit of the last slice is the carry out of bit WIDTH-1.
  if (WIDTH % SLICE != 0) begin : g_pad
    assign final_cout = result_d[WIDTH];
  end else begin : g_nopad
    assign final_cout = sl_cout;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      carry_q     <= 1'b0;
      a_q         <= '0;
      b_q         <= '0;
      mask_q      <= '0;
      result_q    <= '0;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_cout_q  <= 1'b0;
      op_count_q  <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (in_valid) begin
            a_q     <= PW'(in_a);
            b_q     <= PW'(in_b);
            carry_q <= in_cin;
            mask_q  <= in_approx_mask;
            idx_q   <= '0;
            state_q <= StRun;
          end
        end
        StRun: begin
          result_q <= result_d;
          carry_q  <= sl_cout;
          idx_q    <= idx_q + IW'(1);
          if (idx_q == LastIdx) begin
            state_q     <= StDone;
            out_valid_q <= 1'b1;
            out_sum_q   <= result_d[WIDTH-1:0];
            out_cout_q  <= final_cout;
          end
        end
        StDone: begin
          if (out_ready) begin
            state_q     <= StIdle;
            out_valid_q <= 1'b0;
            if (op_count_q != '1) op_count_q <= op_count_q + CNT_W'(1);
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign in_ready  = (state_q == StIdle);
  assign busy      = (state_q != StIdle);
  assign sl_cin    = run & carry_q;
  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_cout  = out_cout_q;
  assign op_count  = op_count_q;

endmodule

// File: tb/tb_approx_slice_add_seq.sv
// Directed and random checks of the slice sequencer against an arithmetic reference.
module tb_approx_slice_add_seq;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic       in_cin;
  logic [2:0] in_approx_mask;
  logic [2:0] sl_a;
  logic [2:0] sl_b;
  logic       sl_cin;
  logic       sl_sel_approx;
  logic [2:0] sl_sum;
  logic       sl_cout;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_sum;
  logic       out_cout;
  logic       busy;
  logic [1:0] op_count;

  int total;
  int bad;
  int ops;
  int exp_sa[3];
  int exp_sb[3];
  int exp_sc[3];
  int exp_sx[3];
  int exp_sum;
  int exp_cout;
  logic [3:0] unit_t;

  approx_slice_add_seq #(
    .WIDTH (8),
    .SLICE (3),
    .CNT_W (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_cin         (in_cin),
    .in_approx_mask (in_approx_mask),
    .sl_a           (sl_a),
    .sl_b           (sl_b),
    .sl_cin         (sl_cin),
    .sl_sel_approx  (sl_sel_approx),
    .sl_sum         (sl_sum),
    .sl_cout        (sl_cout),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_sum        (out_sum),
    .out_cout       (out_cout),
    .busy           (busy),
    .op_count       (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External slice unit: exact ripple add, or approximate a^b with no carry.
  always_comb begin
    unit_t  = '0;
    sl_sum  = '0;
    sl_cout = 1'b0;
    if (sl_sel_approx) begin
      sl_sum = sl_a ^ sl_b;
    end else begin
      unit_t  = {1'b0, sl_a} + {1'b0, sl_b} + {3'b0, sl_cin};
      sl_sum  = unit_t[2:0];
      sl_cout = unit_t[3];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compute_ref(input int a, input int b, input int cin, input int m);
    int c;
    int r;
    c = cin;
    r = 0;
    for (int i = 0; i < 3; i++) begin
      int as_v;
      int bs_v;
      int s;
      as_v = (a >> (3 * i)) & 7;
      bs_v = (b >> (3 * i)) & 7;
      exp_sa[i] = as_v;
      exp_sb[i] = bs_v;
      exp_sc[i] = c;
      exp_sx[i] = (m >> i) & 1;
      if (((m >> i) & 1) != 0) begin
        s = as_v ^ bs_v;
        c = 0;
      end else begin
        s = as_v + bs_v + c;
        c = s >> 3;
        s = s & 7;
      end
      r = r | (s << (3 * i));
    end
    exp_sum  = r & 255;
    exp_cout = (r >> 8) & 1;
  endtask

  // Entered and left #1 after a rising edge.
  task automatic run_op(input int a, input int b, input int cin, input int m, input int hold);
    int cycles;
    compute_ref(a, b, cin, m);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_a           = 8'(a);
    in_b           = 8'(b);
    in_cin         = 1'(cin);
    in_approx_mask = 3'(m);
    in_valid       = 1'b1;
    @(posedge clk); #1;
    in_valid       = 1'b0;
    in_a           = ~in_a;
    in_b           = 8'($urandom);
    in_cin         = ~in_cin;
    in_approx_mask = ~in_approx_mask;
    cycles = 0;
    while (!out_valid && cycles < 10) begin
      if (cycles < 3) begin
        check("sl_a", 32'(sl_a), 32'(exp_sa[cycles]));
        check("sl_b", 32'(sl_b), 32'(exp_sb[cycles]));
        check("sl_cin", 32'(sl_cin), 32'(exp_sc[cycles]));
        check("sl_sel_approx", 32'(sl_sel_approx), 32'(exp_sx[cycles]));
        check("busy_run", 32'(busy), 32'd1);
      end
      @(posedge clk); #1;
      cycles++;
    end
    check("latency", 32'(cycles), 32'd3);
    check("out_sum", 32'(out_sum), 32'(exp_sum));
    check("out_cout", 32'(out_cout), 32'(exp_cout));
    for (int k = 0; k < hold; k++) begin
      in_valid = 1'b1;
      in_a     = 8'hAA;
      @(posedge clk); #1;
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_sum", 32'(out_sum), 32'(exp_sum));
      check("hold_cout", 32'(out_cout), 32'(exp_cout));
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ops++;
    check("op_count", 32'(op_count), 32'((ops > 3) ? 3 : ops));
    check("post_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
    check("post_sum_kept", 32'(out_sum), 32'(exp_sum));
  endtask

  initial begin
    total          = 0;
    bad            = 0;
    ops            = 0;
    rst_n          = 1'b0;
    in_valid       = 1'b0;
    in_a           = '0;
    in_b           = '0;
    in_cin         = 1'b0;
    in_approx_mask = '0;
    out_ready      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_sum", 32'(out_sum), 32'd0);
    check("rst_out_cout", 32'(out_cout), 32'd0);
    check("rst_op_count", 32'(op_count), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sl_a", 32'(sl_a), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;

    run_op('hFF, 'h01, 0, 0, 0);
    check("chain_sum", 32'(out_sum), 32'h00);
    check("chain_cout", 32'(out_cout), 32'd1);
    run_op('h0F, 'h01, 0, 1, 0);
    check("approx_sum", 32'(out_sum), 32'h0E);
    check("approx_cout", 32'(out_cout), 32'd0);
    run_op('h0F, 'h01, 0, 0, 0);
    check("exact_sum", 32'(out_sum), 32'h10);
    run_op('h12, 'h34, 0, 0, 5);
    check("bp_sum", 32'(out_sum), 32'h46);

    // Reset while the second slice is on the unit.
    in_a     = 8'h5A;
    in_b     = 8'h3C;
    in_cin   = 1'b1;
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    check("mid_busy", 32'(busy), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_sum", 32'(out_sum), 32'd0);
    check("mid_rst_cout", 32'(out_cout), 32'd0);
    check("mid_rst_count", 32'(op_count), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    check("mid_rst_sl_a", 32'(sl_a), 32'd0);
    check("mid_rst_sl_cin", 32'(sl_cin), 32'd0);
    ops = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    run_op('h80, 'h80, 1, 0, 0);
    check("rst_after_sum", 32'(out_sum), 32'h01);
    check("rst_after_cout", 32'(out_cout), 32'd1);
    run_op('hB5, 'h6E, 0, 0, 1);
    check("seq_sum", 32'(out_sum), 32'h23);
    check("seq_cout", 32'(out_cout), 32'd1);

    for (int n = 0; n < 20; n++) begin
      run_op(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
             int'($urandom_range(0, 2)));
    end
    check("sat_count", 32'(op_count), 32'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
